sweep_peak_tracker: RTL and testbench

- Generalised successor of the running-max register chain in the sunflower datapath.
- Drives a full angular sweep of the panel over N_POS positions:
  - hands each step to the motor controller via a req/ack handshake;
  - waits a settle time;
  - averages 2^AVG_LOG2 ADC samples per position.
- Reports the peak averaged voltage and the position index where it occurred.
- Sits between the ADC pin-capture logic and the BCD/7-segment display and angle controller.

---
 rtl/sunflower_pkg.sv | 28 ++
 rtl/pos_averager.sv | 47 ++++
 rtl/sweep_peak_tracker.sv | 131 +++++++++++++
 tb/tb_sweep_peak_tracker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sunflower_pkg.sv
// Shared types and helpers for the sunflower sweep datapath.
package sunflower_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_STEP,
    ST_DONE
  } sweep_state_e;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pos_averager.sv
// Accumulates 2^AVG_LOG2 samples for one sweep position and exposes the
// truncated mean. avg_ready flags the cycle the final sample is taken, so the
// mean is valid on avg from the following cycle onward.
module pos_averager
  import sunflower_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 2
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] avg,
  output logic              avg_ready
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  // One spare bit so the count is never zero-width when AVG_LOG2 == 0.
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Running sum and sample count; clear wins over a coincident sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      acc <= acc + ACC_W'(sample_data);
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Divide by the sample count is a plain drop of the low bits.
  always_comb begin
    avg       = acc[ACC_W-1:AVG_LOG2];
    avg_ready = sample_valid && !clear && (cnt == LAST_CNT);
  end

endmodule

// File: rtl/sweep_peak_tracker.sv
// Steps the panel through N_POS positions, averages the ADC at each one after
// a settle delay and keeps the largest average together with its position.
module sweep_peak_tracker
  import sunflower_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int N_POS      = 16,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 1000,
  localparam int INDEX_W   = clog2(N_POS)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample_data,
  output logic               step_req,
  input  logic               step_ack,
  output logic               busy,
  output logic [INDEX_W-1:0] pos,
  output logic [DATA_W-1:0]  peak_value,
  output logic [INDEX_W-1:0] peak_index,
  output logic               peak_valid,
  output logic               done
);

  localparam int SW = clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE_CYC);
  localparam logic [INDEX_W-1:0] LAST_POS    = INDEX_W'(N_POS - 1);

  sweep_state_e      state, state_nxt;
  logic [SW-1:0]     settle_cnt;
  logic [DATA_W-1:0] avg;
  logic              avg_ready;
  logic              acc_clear;
  logic              acc_valid;
  logic              go;
  logic              cancel;

  // Start is honoured only from IDLE and loses to a simultaneous abort.
  assign go     = (state == ST_IDLE) && start && !abort;
  assign cancel = (state != ST_IDLE) && abort;

  // The averager restarts while the panel settles and only listens in ACCUM.
  assign acc_clear = (state == ST_SETTLE);
  assign acc_valid = sample_valid && (state == ST_ACCUM);

  pos_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .reset        (reset),
    .clear        (acc_clear),
    .sample_valid (acc_valid),
    .sample_data  (sample_data),
    .avg          (avg),
    .avg_ready    (avg_ready)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore outputs; abort overrides every non-IDLE transition.
  always_comb begin
    state_nxt = state;
    step_req  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = ST_SETTLE;
      end
      ST_SETTLE:  if (settle_cnt == SW'(1)) state_nxt = ST_ACCUM;
      ST_ACCUM:   if (avg_ready) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = (pos == LAST_POS) ? ST_DONE : ST_STEP;
      ST_STEP: begin
        step_req = 1'b1;
        if (step_ack) state_nxt = ST_SETTLE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cancel) state_nxt = ST_IDLE;
  end

  // Settle counter, position, and peak tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      pos        <= '0;
      peak_value <= '0;
      peak_index <= '0;
      peak_valid <= 1'b0;
    end else if (cancel) begin
      // Partial peak stays visible after an abort; only the valid flag drops.
      peak_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          settle_cnt <= SETTLE_LOAD;
          pos        <= '0;
          peak_value <= '0;
          peak_index <= '0;
          peak_valid <= 1'b0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt - SW'(1);
        // Strict compare so ties keep the earliest position.
        ST_COMPARE: if (avg > peak_value) begin
          peak_value <= avg;
          peak_index <= pos;
        end
        ST_STEP: if (step_ack) begin
          pos        <= pos + INDEX_W'(1);
          settle_cnt <= SETTLE_LOAD;
        end
        ST_DONE: peak_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// Directed bench for sweep_peak_tracker with N_POS=4, AVG_LOG2=1, SETTLE_CYC=2.
module tb_sweep_peak_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, sample_valid, step_ack;
  logic [11:0] sample_data;
  logic        step_req, busy, peak_valid, done;
  logic [1:0]  pos, peak_index;
  logic [11:0] peak_value;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int sweep_d0 = 0;
  int ack_delay = 0;
  int req_cyc = 0;
  logic [11:0] smp [8];

  always #5 clk = ~clk;

  sweep_peak_tracker #(
    .DATA_W(12), .N_POS(4), .AVG_LOG2(1), .SETTLE_CYC(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .step_req(step_req), .step_ack(step_ack), .busy(busy), .pos(pos),
    .peak_value(peak_value), .peak_index(peak_index),
    .peak_valid(peak_valid), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Motor model: acks after ack_delay extra cycles of step_req.
  always @(negedge clk) begin
    if (step_req) begin
      req_cyc  = req_cyc + 1;
      step_ack = (req_cyc > ack_delay);
    end else begin
      req_cyc  = 0;
      step_ack = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Runs one sweep using smp[]; stops early on abort_pos or a mid-STEP reset.
  task automatic run_sweep(input string tag, input int delay_pos, input int delay,
                           input int abort_pos, input bit junk, input bit glitch,
                           input bit rst_mid);
    int w;
    bit pos_bad;
    sweep_d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_delay    = (i == delay_pos) ? delay : 0;
      sample_valid = junk;
      sample_data  = 12'hFFF;
      if (glitch && i == 2) start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      if (i == abort_pos) begin
        sample_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk({tag, "_abort_busy"}, busy, 0);
        chk({tag, "_abort_req"}, step_req, 0);
        chk({tag, "_abort_pvalid"}, peak_valid, 0);
        @(negedge clk);
        chk({tag, "_abort_nodone"}, done_cnt - sweep_d0, 0);
        return;
      end
      sample_valid = 1'b1; sample_data = smp[2*i];
      @(negedge clk); sample_data = smp[2*i+1];
      @(negedge clk); sample_valid = 1'b0;
      @(negedge clk);
      if (i == 3) begin
        chk({tag, "_done_pulse"}, done, 1);
      end else begin
        if (rst_mid && i == delay_pos) begin
          chk({tag, "_pre_rst_req"}, step_req, 1);
          #2 reset = 1'b1;
          #1;
          chk({tag, "_rst_req"}, step_req, 0);
          chk({tag, "_rst_busy"}, busy, 0);
          chk({tag, "_rst_pos"}, pos, 0);
          chk({tag, "_rst_pval"}, peak_value, 0);
          chk({tag, "_rst_pidx"}, peak_index, 0);
          chk({tag, "_rst_pvalid"}, peak_valid, 0);
          chk({tag, "_rst_done"}, done, 0);
          @(negedge clk); reset = 1'b0;
          @(negedge clk);
          chk({tag, "_post_rst_idle"}, busy, 0);
          chk({tag, "_post_rst_req"}, step_req, 0);
          ack_delay = 0;
          return;
        end
        w = 0;
        pos_bad = 1'b0;
        while (step_req && w < 50) begin
          if (pos != 2'(i)) pos_bad = 1'b1;
          @(negedge clk);
          w++;
        end
        if (w >= 50) chk({tag, "_step_timeout"}, 1, 0);
        chk({tag, "_pos_adv"}, pos, i + 1);
        if (i == delay_pos) begin
          chk({tag, "_req_len"}, w, delay + 1);
          chk({tag, "_pos_hold"}, pos_bad, 0);
        end
      end
    end
    ack_delay = 0;
  endtask

  task automatic chk_result(input string tag, input int exp_v, input int exp_i);
    @(negedge clk);
    chk({tag, "_peak_value"}, peak_value, exp_v);
    chk({tag, "_peak_index"}, peak_index, exp_i);
    chk({tag, "_peak_valid"}, peak_valid, 1);
    chk({tag, "_pos"}, pos, 3);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_cnt"}, done_cnt - sweep_d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sample_valid = 1'b0; sample_data = '0; step_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", step_req, 0);
    chk("rst_pos", pos, 0);
    chk("rst_pval", peak_value, 0);
    chk("rst_pvalid", peak_valid, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic sweep, averages 101, 301, 200, 51.
    smp = '{12'd100, 12'd102, 12'd300, 12'd302, 12'd200, 12'd200, 12'd50, 12'd52};
    run_sweep("basic", -1, 0, -1, 0, 0, 0);
    chk_result("basic", 301, 1);

    // 2: tie keeps earliest; averages 500, 700, 700, 10 with truncation.
    smp = '{12'd499, 12'd501, 12'd700, 12'd701, 12'd699, 12'd701, 12'd10, 12'd11};
    run_sweep("tie", -1, 0, -1, 0, 0, 0);
    chk_result("tie", 700, 1);

    // 3: ack held off 5 cycles at position 1; averages 6, 8, 4000, 9.
    smp = '{12'd5, 12'd7, 12'd8, 12'd8, 12'd4000, 12'd4001, 12'd9, 12'd9};
    run_sweep("slowack", 1, 5, -1, 0, 0, 0);
    chk_result("slowack", 4000, 2);

    // 4: 4095 offered while settling must be ignored; averages 1, 2, 3, 0.
    smp = '{12'd1, 12'd1, 12'd2, 12'd2, 12'd3, 12'd3, 12'd0, 12'd0};
    run_sweep("settle_junk", -1, 0, -1, 1, 0, 0);
    chk_result("settle_junk", 3, 2);

    // All-zero sweep.
    smp = '{default: 12'd0};
    run_sweep("zero", -1, 0, -1, 0, 0, 0);
    chk_result("zero", 0, 0);

    // 5: abort in ACCUM at position 2; partial peak stays, next start clears it.
    smp = '{12'd100, 12'd102, 12'd300, 12'd302, 12'd200, 12'd200, 12'd50, 12'd52};
    run_sweep("abort", -1, 0, 2, 0, 0, 0);
    chk("abort_partial_peak", peak_value, 301);
    chk("abort_partial_idx", peak_index, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_clears_peak", peak_value, 0);
    chk("restart_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_settle_idle", busy, 0);

    // abort together with start in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // 6: async reset mid-STEP, then a sweep with a stray start while busy.
    run_sweep("rst_step", 1, 10, -1, 0, 0, 1);
    run_sweep("glitch", -1, 0, -1, 0, 1, 0);
    chk_result("glitch", 301, 1);
    repeat (4) @(negedge clk);
    chk("glitch_no_extra_done", done_cnt - sweep_d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
